// File: rtl/usb_tx_pkg.sv
// Shared encodings and constants for the USB full-speed transmit serializer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PID    = 3'd1,
        ST_SYNC   = 3'd2,
        ST_DATA   = 3'd3,
        ST_CRC_HI = 3'd4,
        ST_CRC_LO = 3'd5,
        ST_EOP1   = 3'd6,
        ST_EOP2   = 3'd7
    } tx_phase_t;

    // Line levels packed as {dplus, dminus}
    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10
    } line_t;

    localparam int STUFF_LIMIT = 6;
    localparam int ONES_W      = 3;
    localparam int TIMER_W     = 4;
    localparam int PHASE_W     = 2;

    // 8 + 8 + 9 = 25 clks of 100 MHz per 3 bits of 12 Mb/s
    localparam logic [TIMER_W-1:0] PERIOD_0 = 4'd8;
    localparam logic [TIMER_W-1:0] PERIOD_1 = 4'd8;
    localparam logic [TIMER_W-1:0] PERIOD_2 = 4'd9;
    localparam logic [PHASE_W-1:0] LAST_PHASE = 2'd2;

    function automatic logic [TIMER_W-1:0] period_of(input logic [PHASE_W-1:0] phase);
        case (phase)
            2'd0:    period_of = PERIOD_0;
            2'd1:    period_of = PERIOD_1;
            default: period_of = PERIOD_2;
        endcase
    endfunction

    function automatic line_t nrzi_toggle(input line_t line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

    function automatic logic carries_bits(input logic [2:0] state_val);
        return state_val inside {ST_PID, ST_SYNC, ST_DATA, ST_CRC_HI, ST_CRC_LO};
    endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// 12 Mb/s bit-tick generator from a 100 MHz clock using an 8/8/9 period rotation.
module usb_tx_bit_timer
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic enable_timer,
    input  logic clear_timer,
    output logic tick
);

    logic [TIMER_W-1:0] remain;
    logic [PHASE_W-1:0] phase;

    // remain==0 means "start of a period": the next enabled clk loads period-1,
    // so the terminal count of 1 lands exactly period clks after the load.
    assign tick = enable_timer && !clear_timer && (remain == 4'd1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            remain <= '0;
            phase  <= '0;
        end else if (clear_timer) begin
            remain <= '0;
            phase  <= '0;
        end else if (enable_timer) begin
            if (remain == '0) begin
                remain <= period_of(phase) - 4'd1;
            end else begin
                remain <= remain - 4'd1;
            end
            if (tick) begin
                phase <= (phase == LAST_PHASE) ? '0 : phase + 2'd1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit serializer: byte shift-out, bit stuffing, NRZI and EOP line drive.
//
// line state | meaning
// LINE_J     | idle / differential 1 level (D+=1, D-=0)
// LINE_K     | differential 0 level (D+=0, D-=1)
// LINE_SE0   | single-ended zero during EOP1
module usb_tx_serializer
    import usb_tx_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable_timer,
    input  logic       clear_timer,
    input  logic       load_enable,
    input  logic [7:0] data_pts,
    input  logic [2:0] state_val,
    output logic       flag,
    output logic       dplus_out,
    output logic       dminus_out
);

    logic              tick;
    line_t             line_q;
    line_t             line_next;
    logic [6:0]        shift_reg;
    logic [6:0]        shift_next;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_next;
    logic [ONES_W-1:0] ones_cnt;
    logic [ONES_W-1:0] ones_next;
    logic              flag_next;
    logic              tx_bit;

    usb_tx_bit_timer u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable_timer (enable_timer),
        .clear_timer  (clear_timer),
        .tick         (tick)
    );

    assign {dplus_out, dminus_out} = line_q;

    always_comb begin
        line_next    = line_q;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        ones_next    = ones_cnt;
        flag_next    = 1'b0;
        tx_bit       = 1'b1;
        if (tick) begin
            if (carries_bits(state_val)) begin
                if (ones_cnt == ONES_W'(STUFF_LIMIT)) begin
                    // stuffed 0: data position and shift register stay put
                    tx_bit    = 1'b0;
                    ones_next = '0;
                end else begin
                    if (bit_cnt == 3'd0) begin
                        tx_bit     = load_enable ? data_pts[0] : 1'b1;
                        shift_next = load_enable ? data_pts[7:1] : 7'h7f;
                    end else begin
                        tx_bit     = shift_reg[0];
                        shift_next = {1'b0, shift_reg[6:1]};
                    end
                    ones_next    = tx_bit ? ones_cnt + 3'd1 : '0;
                    bit_cnt_next = bit_cnt + 3'd1;
                    flag_next    = (bit_cnt == 3'd7);
                end
                line_next = tx_bit ? line_q : nrzi_toggle(line_q);
            end else if (state_val == ST_EOP1) begin
                // bit_cnt keeps pacing flag so upstream can leave EOP1
                line_next    = LINE_SE0;
                ones_next    = '0;
                bit_cnt_next = bit_cnt + 3'd1;
                flag_next    = (bit_cnt == 3'd7);
            end else begin
                // idle and EOP2 re-arm the byte framing for the next packet
                line_next    = LINE_J;
                ones_next    = '0;
                bit_cnt_next = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line_q    <= LINE_J;
            shift_reg <= '0;
            bit_cnt   <= '0;
            ones_cnt  <= '0;
            flag      <= 1'b0;
        end else if (clear_timer) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
            flag     <= 1'b0;
        end else begin
            line_q    <= line_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            ones_cnt  <= ones_next;
            flag      <= flag_next;
        end
    end

endmodule
